// File: rtl/ppu_palram_arbiter_pkg.sv
// rtl/ppu_palram_arbiter_pkg.sv - shared PPU palette RAM requester ids and default geometry
package ppu_palram_arbiter_pkg;

  typedef enum logic [0:0] {
    PAL_REQ_BG  = 1'b0,
    PAL_REQ_SPR = 1'b1
  } pal_req_e;

  localparam int PALRAM_ADDR_W = 9;
  localparam int PALRAM_DATA_W = 64;

endpackage

// File: rtl/ppu_palram_arbiter_rr.sv
// rtl/ppu_palram_arbiter_rr.sv - round-robin one-hot grant with rotating priority pointer
module rr_arbiter
  import ppu_palram_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] gnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;

  // Scan from the pointer upward with wraparound; the first requester found wins.
  always_comb begin
    int               sum;
    logic             found;
    logic [PTR_W-1:0] idx;
    gnt      = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    sum      = 0;
    idx      = '0;
    if (advance) begin
      for (int i = 0; i < N_REQ; i++) begin
        sum = int'(rr_ptr_q) + i;
        if (sum >= N_REQ) begin
          sum = sum - N_REQ;
        end
        idx = PTR_W'(sum);
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          rr_ptr_d = (sum == N_REQ - 1) ? '0 : PTR_W'(sum + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/ppu_palram_arbiter.sv
// rtl/ppu_palram_arbiter.sv - read-only palette RAM port A arbiter with in-order tagged returns
module ppu_palram_arbiter
  import ppu_palram_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_W     = PALRAM_ADDR_W,
  parameter int DATA_W     = PALRAM_DATA_W,
  parameter int RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic [ADDR_W-1:0]       palram_addr_a,
  output logic                    palram_wren_a,
  output logic [DATA_W-1:0]       palram_wrdata_a,
  input  logic [DATA_W-1:0]       palram_rddata_a
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                  arb_en;
  logic                  gnt_any;
  logic [IDX_W-1:0]      gnt_idx;
  logic [ADDR_W-1:0]     addr_q;
  logic [ADDR_W-1:0]     addr_d;
  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [RD_LATENCY-1:0] tag_vld_d;
  logic [IDX_W-1:0]      tag_idx_q [RD_LATENCY];
  logic [IDX_W-1:0]      tag_idx_d [RD_LATENCY];
  logic [DATA_W-1:0]     rdata_q;
  logic [DATA_W-1:0]     rdata_d;

  assign palram_wren_a   = 1'b0;
  assign palram_wrdata_a = '0;

  // Gating with rst_n keeps gnt low while reset is held.
  assign arb_en = en & rst_n;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .advance(arb_en),
    .gnt    (gnt)
  );

  assign gnt_any = |gnt;

  always_comb begin
    gnt_idx = '0;
    addr_d  = addr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = IDX_W'(i);
        addr_d  = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign palram_addr_a = addr_d;

  // Stage k holds the grant issued k+1 cycles ago; the last stage lines up with RAM data.
  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = gnt_any;
    tag_idx_d[0] = gnt_idx;
    for (int k = 1; k < RD_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end
  end

  always_comb begin
    rvalid  = '0;
    rdata   = rdata_q;
    if (tag_vld_q[RD_LATENCY-1]) begin
      rvalid[tag_idx_q[RD_LATENCY-1]] = 1'b1;
      rdata = palram_rddata_a;
    end
    rdata_d = rdata;
  end

  assign busy = |tag_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      tag_vld_q <= '0;
      rdata_q   <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_idx_q[k] <= '0;
      end
    end else begin
      addr_q    <= addr_d;
      tag_vld_q <= tag_vld_d;
      rdata_q   <= rdata_d;
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_idx_q[k] <= tag_idx_d[k];
      end
    end
  end

endmodule

// File: tb/tb_ppu_palram_arbiter.sv
// tb/tb_ppu_palram_arbiter.sv - directed bench for ppu_palram_arbiter at read latency 2 and 3
module tb_ppu_palram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  req;
  logic [8:0]  a0;
  logic [8:0]  a1;
  logic [17:0] req_addr;

  logic [1:0]  gnt2, rvalid2, gnt3, rvalid3;
  logic [63:0] rdata2, rdata3, wrdata2, wrdata3, rd2, rd3;
  logic        busy2, busy3, wren2, wren3;
  logic [8:0]  pa2, pa3;
  logic [8:0]  ap2 [2];
  logic [8:0]  ap3 [3];

  int checks = 0;
  int errors = 0;

  assign req_addr = {a1, a0};

  function automatic logic [63:0] ram_word(input logic [8:0] a);
    return {16'hC0DE, 7'b0, a, 16'h5A5A, 7'b0, ~a};
  endfunction

  ppu_palram_arbiter #(.N_REQ(2), .ADDR_W(9), .DATA_W(64), .RD_LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_addr(req_addr),
    .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2), .busy(busy2),
    .palram_addr_a(pa2), .palram_wren_a(wren2), .palram_wrdata_a(wrdata2),
    .palram_rddata_a(rd2)
  );

  ppu_palram_arbiter #(.N_REQ(2), .ADDR_W(9), .DATA_W(64), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_addr(req_addr),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .busy(busy3),
    .palram_addr_a(pa3), .palram_wren_a(wren3), .palram_wrdata_a(wrdata3),
    .palram_rddata_a(rd3)
  );

  // Palette RAM models: the word appears RD_LATENCY cycles after its address.
  always @(posedge clk) begin
    ap2[0] <= pa2;
    ap2[1] <= ap2[0];
    ap3[0] <= pa3;
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end
  assign rd2 = ram_word(ap2[1]);
  assign rd3 = ram_word(ap3[2]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [1:0] r, input logic [8:0] x0, input logic [8:0] x1);
    @(negedge clk);
    en  = e;
    req = r;
    a0  = x0;
    a1  = x1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] eg   [7];
  logic [1:0] erv2 [7];
  logic [1:0] erv3 [7];

  initial begin
    eg   = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    erv2 = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    erv3 = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};

    rst_n = 1'b0; en = 1'b0; req = 2'b00; a0 = '0; a1 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 64'(gnt2), 64'h0);
    chk("rst_rvalid", 64'(rvalid2), 64'h0);
    chk("rst_busy", 64'(busy2), 64'h0);
    chk("rst_rdata", rdata2, 64'h0);
    chk("rst_addr", 64'(pa2), 64'h0);
    chk("wren_tie", 64'({wren2, wren3}), 64'h0);
    chk("wrdata_tie", wrdata2 | wrdata3, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single background read
    drive(1'b1, 2'b01, 9'h010, 9'h0AB);
    chk("single_gnt", 64'(gnt2), 64'h1);
    chk("single_addr", 64'(pa2), 64'h010);
    chk("single_busy0", 64'(busy2), 64'h0);
    drive(1'b1, 2'b00, 9'h010, 9'h0AB);
    chk("single_gnt_off", 64'(gnt2), 64'h0);
    chk("single_rv_early", 64'(rvalid2), 64'h0);
    chk("single_busy1", 64'(busy2), 64'h1);
    chk("single_addr_hold", 64'(pa2), 64'h010);
    drive(1'b1, 2'b00, 9'h010, 9'h0AB);
    chk("single_rv", 64'(rvalid2), 64'h1);
    chk("single_rdata", rdata2, ram_word(9'h010));
    chk("single_rv3_early", 64'(rvalid3), 64'h0);
    drive(1'b1, 2'b00, 9'h010, 9'h0AB);
    chk("single_rv_off", 64'(rvalid2), 64'h0);
    chk("single_rdata_hold", rdata2, ram_word(9'h010));
    chk("single_busy_done", 64'(busy2), 64'h0);
    chk("single_rv3", 64'(rvalid3), 64'h1);
    chk("single_rdata3", rdata3, ram_word(9'h010));

    // Both requesting from reset
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, (i < 4) ? 2'b11 : 2'b00, 9'h020, 9'h030);
      chk($sformatf("rr_gnt_%0d", i), 64'(gnt2), 64'(eg[i]));
      chk($sformatf("rr_rv2_%0d", i), 64'(rvalid2), 64'(erv2[i]));
      chk($sformatf("rr_rv3_%0d", i), 64'(rvalid3), 64'(erv3[i]));
      if (erv2[i] != 2'b00) begin
        chk($sformatf("rr_rdata2_%0d", i), rdata2, ram_word((erv2[i] == 2'b01) ? 9'h020 : 9'h030));
      end
      if (erv3[i] != 2'b00) begin
        chk($sformatf("rr_rdata3_%0d", i), rdata3, ram_word((erv3[i] == 2'b01) ? 9'h020 : 9'h030));
      end
    end

    // Back-to-back sprite reads at the address extremes
    drive(1'b1, 2'b10, 9'h155, 9'h1FF);
    chk("b2b_gnt0", 64'(gnt2), 64'h2);
    chk("b2b_addr0", 64'(pa2), 64'h1FF);
    drive(1'b1, 2'b10, 9'h155, 9'h000);
    chk("b2b_gnt1", 64'(gnt2), 64'h2);
    chk("b2b_addr1", 64'(pa2), 64'h000);
    drive(1'b1, 2'b00, 9'h155, 9'h000);
    chk("b2b_rv0", 64'(rvalid2), 64'h2);
    chk("b2b_rdata0", rdata2, ram_word(9'h1FF));
    drive(1'b1, 2'b00, 9'h155, 9'h000);
    chk("b2b_rv1", 64'(rvalid2), 64'h2);
    chk("b2b_rdata1", rdata2, ram_word(9'h000));
    drive(1'b1, 2'b00, 9'h155, 9'h000);
    chk("b2b_rv_end", 64'(rvalid2), 64'h0);

    // Enable drop with a read in flight
    drive(1'b1, 2'b11, 9'h040, 9'h050);
    chk("en_gnt_pre", 64'(gnt2), 64'h1);
    chk("en_addr_pre", 64'(pa2), 64'h040);
    drive(1'b0, 2'b11, 9'h040, 9'h050);
    chk("en_off_gnt0", 64'(gnt2), 64'h0);
    chk("en_off_busy", 64'(busy2), 64'h1);
    drive(1'b0, 2'b11, 9'h040, 9'h050);
    chk("en_off_gnt1", 64'(gnt2), 64'h0);
    chk("en_off_rv", 64'(rvalid2), 64'h1);
    chk("en_off_rdata", rdata2, ram_word(9'h040));
    drive(1'b0, 2'b11, 9'h040, 9'h050);
    chk("en_off_gnt2", 64'(gnt2), 64'h0);
    chk("en_off_idle", 64'(busy2), 64'h0);
    chk("en_off_rv_end", 64'(rvalid2), 64'h0);
    drive(1'b1, 2'b11, 9'h040, 9'h050);
    chk("en_on_gnt", 64'(gnt2), 64'h2);
    chk("en_on_addr", 64'(pa2), 64'h050);
    drive(1'b1, 2'b00, 9'h040, 9'h050);
    drive(1'b1, 2'b00, 9'h040, 9'h050);
    chk("en_on_rv", 64'(rvalid2), 64'h2);
    chk("en_on_rdata", rdata2, ram_word(9'h050));

    // Reset one cycle after a grant
    drive(1'b1, 2'b01, 9'h060, 9'h070);
    chk("mr_gnt", 64'(gnt2), 64'h1);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b11;
    #1;
    chk("mr_gnt_in_rst", 64'(gnt2), 64'h0);
    chk("mr_busy_in_rst", 64'(busy2), 64'h0);
    chk("mr_rdata_in_rst", rdata2, 64'h0);
    chk("mr_addr_in_rst", 64'(pa2), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b00;
    #1;
    chk("mr_rv_after0", 64'(rvalid2), 64'h0);
    chk("mr_busy_after", 64'(busy2), 64'h0);
    drive(1'b1, 2'b00, 9'h060, 9'h070);
    chk("mr_rv_after1", 64'(rvalid2 | rvalid3), 64'h0);
    drive(1'b1, 2'b11, 9'h060, 9'h070);
    chk("mr_next_gnt", 64'(gnt2), 64'h1);
    chk("mr_next_gnt3", 64'(gnt3), 64'h1);
    drive(1'b1, 2'b00, 9'h060, 9'h070);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_palram_arbiter.md
PPU_PALRAM_ARBITER -- requirements
Module: ppu_palram_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, 2, number of requesters (0 = background, 1 = sprite).
REQ-002 SHALL have parameter ADDR_W, 9, palette RAM word-address width.
REQ-003 SHALL have parameter DATA_W, 64, palette RAM word width.
REQ-004 SHALL have parameter RD_LATENCY, 2, cycles from address presentation to valid palram_rddata_a (allowed range 1..4).
REQ-005 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  arbitration enable; no grants while low.
REQ-008 SHALL have port req  input  N_REQ  per-requester read request, level.
REQ-009 SHALL have port req_addr  input  N_REQ x ADDR_W  per-requester read address.
REQ-010 SHALL have port gnt  output  N_REQ  one-hot grant; the address is accepted in the same cycle.
REQ-011 SHALL have port rvalid  output  N_REQ  one-cycle pulse per returned word.
REQ-012 SHALL have port rdata  output  DATA_W  returned word, shared by all requesters and qualified by rvalid.
REQ-013 SHALL have port busy  output  1  high while any read is in flight.
REQ-014 SHALL have ports palram_addr_a (output, ADDR_W), palram_wren_a (output, 1), palram_wrdata_a (output, DATA_W) and palram_rddata_a (input, DATA_W), connecting to the PPU-facing VRAM interface port A.

Function
REQ-015 SHALL tie palram_wren_a to 0 and palram_wrdata_a to 0 permanently.
REQ-016 SHALL drive gnt combinationally: when en=1 and req is non-zero, exactly one bit is set, selecting the first requesting index at or after rr_ptr (round-robin); otherwise gnt=0.
REQ-017 SHALL advance rr_ptr to (granted index + 1) mod N_REQ on every grant and SHALL hold rr_ptr when there is no grant.
REQ-018 SHALL drive palram_addr_a combinationally with req_addr of the granted requester; with no grant it SHALL hold the last granted address (0 after reset).
REQ-019 SHALL sustain one grant per cycle with no bubbles between back-to-back grants.
REQ-020 SHALL track each grant in a RD_LATENCY-deep tag pipeline (valid bit + requester index), shifted every cycle.
REQ-021 SHALL, when the tag pipeline's last stage is valid, pulse rvalid[index]=1 for one cycle and set rdata = palram_rddata_a in that cycle; the total grant-to-rvalid latency is exactly RD_LATENCY cycles.
REQ-022 SHALL hold rdata at its last returned value when rvalid=0.
REQ-023 SHALL return responses in grant order; at most one rvalid bit may be high per cycle.
REQ-024 SHALL make busy=1 whenever any tag stage is valid.
REQ-025 SHALL let reads already in flight complete normally when en is deasserted; only new grants are blocked.
REQ-026 SHALL, when all requesters request simultaneously, grant exactly one of them per cycle in rotating order, so that no requester waits more than N_REQ-1 cycles while req stays high.
REQ-027 SHALL ignore req_addr of a requester that is not granted.

Reset
REQ-028 SHALL, on rst_n low and asynchronously, clear rr_ptr to 0, all tag valid bits, rvalid, rdata, busy and the held address; gnt is 0 during reset.
REQ-029 SHALL discard reads in flight when reset asserts mid-operation; no rvalid for them may appear after reset is released.

Structure
REQ-030 SHALL place the requester-index enum (PAL_REQ_BG=0, PAL_REQ_SPR=1) and the default PALRAM_ADDR_W/PALRAM_DATA_W constants in the shared PPU package.
REQ-031 SHALL implement the round-robin grant logic as a single sub-module, rr_arbiter (parameter N_REQ; ports req, advance, gnt); the tag pipeline stays inline.

Verification
REQ-032 SHALL cover: en=1, req=01 with addr 9'h010 for one cycle -> gnt=01 in the same cycle, palram_addr_a=9'h010, rvalid=01 exactly 2 cycles later with rdata equal to the RAM word at 0x010.
REQ-033 SHALL cover: req=11 held for 4 cycles from reset -> gnt sequence 01,10,01,10; rvalid sequence the same, delayed 2 cycles.
REQ-034 SHALL cover: back-to-back requester-1 reads at 0x1FF then 0x000 -> two consecutive rvalid=10 pulses with the matching data, no bubble.
REQ-035 SHALL cover: req=11 with en=0 -> gnt=00 and busy=0; in-flight reads issued just before en fell still return.
REQ-036 SHALL cover: rst_n pulsed low one cycle after a grant -> no rvalid after reset is released, busy=0, and the next grant goes to requester 0.
REQ-037 SHALL cover: RD_LATENCY=3 build -> every rvalid arrives exactly 3 cycles after its grant.
